// File: rtl/nibble_serial_add_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width for n nibbles; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_add_seq_carry_unit.sv
// Four-bit parallel-prefix carry slice: internal carries and carry-out from P/G/cin.
// Latency: combinational, zero cycles.
// Backpressure: none, pure logic.
module nibble_carry_unit (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [3:0] c,
    output logic       cout
);

    // Pairwise group generate/propagate for bits [1:0] and [3:2].
    logic g10;
    logic p10;
    logic g32;
    logic p32;

    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];

    // Carries into each bit; c[2] is the midpoint that feeds both upper bits.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g10 | (p10 & cin);
    assign c[3] = g[2] | (p[2] & c[2]);
    assign cout = g32 | (p32 & c[2]);

endmodule

// File: rtl/nibble_serial_add_seq.sv
// WIDTH-bit add/subtract computed one nibble per clock through a single carry slice.
// Latency: accept at edge t, result and flags visible after edge t+WIDTH/4.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module nibble_serial_add_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int IW = idx_width(N);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
        $error("nibble_serial_add_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t                state;
    logic [IW-1:0]         idx;
    logic                  cy_reg;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;

    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   c_nib;
    logic                  c_out;
    logic [NIBBLE_W-1:0]   nib_sum;
    logic [WIDTH-1:0]      sum_next;
    logic                  last_nib;

    // Held low during reset so nothing is accepted until the block is truly idle.
    assign in_ready = (state == IDLE) && !rst;
    assign last_nib = (idx == IW'(N - 1));

    // Pick the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                a_nib = a_reg[k*NIBBLE_W +: NIBBLE_W];
                b_nib = b_reg[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_carry_unit u_carry (
        .p    (a_nib ^ b_nib),
        .g    (a_nib & b_nib),
        .cin  (cy_reg),
        .c    (c_nib),
        .cout (c_out)
    );

    assign nib_sum = a_nib ^ b_nib ^ c_nib;

    // Result word with the current nibble merged in; also feeds the zero flag on the last step.
    always_comb begin
        sum_next = sum;
        for (int k = 0; k < N; k++) begin
            if (idx == IW'(k)) begin
                sum_next[k*NIBBLE_W +: NIBBLE_W] = nib_sum;
            end
        end
    end

    // Sequencer: accept operands, walk nibbles LSB first, then hold the result for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cy_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
                        b_reg  <= sub ? ~b : b;
                        cy_reg <= sub;
                        sum    <= '0;
                        idx    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    sum    <= sum_next;
                    cy_reg <= c_out;
                    idx    <= idx + IW'(1);
                    if (last_nib) begin
                        carry     <= c_out;
                        overflow  <= c_nib[3] ^ c_out;
                        zero      <= (sum_next == '0);
                        idx       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed self-checking bench for nibble_serial_add_seq at WIDTH=16.
// Latency: expects result visible on the 5th sample after the accept edge.
// Backpressure: exercises held DONE, mid-run reset and back-to-back streaming.
module tb_nibble_serial_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    nibble_serial_add_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent reference: returns {carry, overflow, zero, sum}.
    function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] yy;
        logic [16:0] f;
        logic        v;
        yy = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + 17'(s);
        v  = (x[15] == yy[15]) && (f[15] != x[15]);
        return {f[16], v, (f[15:0] == 16'h0000), f[15:0]};
    endfunction

    // One directed operation; called just after a negedge with the DUT idle.
    task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic ts, input logic [15:0] esum, input logic ec,
                      input logic ev, input logic ez, input bit hold);
        int cnt;
        bit rdy_seen;
        out_ready = !hold;
        a         = ta;
        b         = tb_v;
        sub       = ts;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        cnt       = 1;
        rdy_seen  = in_ready;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
            rdy_seen = rdy_seen | in_ready;
        end
        chk({tag, "_lat"}, 32'(cnt), 32'd5);
        chk({tag, "_rdy_low"}, 32'(rdy_seen), 32'd0);
        chk({tag, "_result"}, 32'({carry, overflow, zero, sum}), 32'({ec, ev, ez, esum}));
        if (!hold) begin
            @(negedge clk);
            chk({tag, "_release"}, 32'({out_valid, in_ready, busy}), 32'b010);
        end
    endtask

    initial begin
        logic [15:0] ta [8];
        logic [15:0] tbv[8];
        logic        ts [8];
        logic [18:0] exp_r[8];
        int          cyc;
        int          acc;
        int          res;
        int          last_acc;
        bit          pend;
        bit          ov_seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 32'({in_ready, out_valid, busy, carry, overflow, zero}), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        op("add1",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
        op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset during the second RUN cycle; flags were left set by the previous op.
        a        = 16'h1234;
        b        = 16'h0FFF;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctl", 32'({in_ready, out_valid, busy, carry, overflow, zero}), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        ov_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        chk("midrst_no_out", 32'(ov_seen), 32'd0);
        op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);

        op("ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0);
        op("sub1",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        op("sub2",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Backpressure: result must hold while inputs churn.
        op("bp",    16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a        = 16'($urandom);
            b        = 16'($urandom);
            sub      = 1'($urandom);
            @(negedge clk);
            chk("bp_hold", 32'({out_valid, in_ready, carry, overflow, zero, sum}),
                32'({1'b1, 1'b0, 3'b000, 16'h2233}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'({out_valid, in_ready}), 32'b01);

        // Back-to-back stream with in_valid held high.
        for (int i = 0; i < 8; i++) begin
            ta[i]    = 16'($urandom);
            tbv[i]   = 16'($urandom);
            ts[i]    = 1'($urandom);
            exp_r[i] = model(ta[i], tbv[i], ts[i]);
        end
        cyc      = 0;
        acc      = 0;
        res      = 0;
        last_acc = 0;
        a        = ta[0];
        b        = tbv[0];
        sub      = ts[0];
        in_valid = 1'b1;
        while (res < 8 && cyc < 300) begin
            pend = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (pend) begin
                if (acc > 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                acc++;
                if (acc < 8) begin
                    a   = ta[acc];
                    b   = tbv[acc];
                    sub = ts[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (res < 8) chk("b2b_result", 32'({carry, overflow, zero, sum}), 32'(exp_r[res]));
                res++;
            end
        end
        chk("b2b_count", 32'(res), 32'd8);
        chk("b2b_accepts", 32'(acc), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
